// File: rtl/sel_scan_8.sv
// One-hot scan generator for an 8:1 one-hot selector, stepping every PERIOD enabled cycles.
// Optional macro SEL_SCAN_8_IDLE_EN adds an IDLE state that parks sel at 8'h00 while en=0.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_RUN  | sel = 1<<idx, prescaler counts enabled cycles, steps idx
// S_IDLE | (SEL_SCAN_8_IDLE_EN only) sel = 0, idx retained, cnt cleared

module sel_scan_8 #(
  parameter int unsigned PERIOD = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       dir,
  input  logic       load,
  input  logic [2:0] load_idx,
  output logic [7:0] sel,
  output logic [2:0] idx,
  output logic       step,
  output logic       wrap
);

  localparam int unsigned   CW       = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

`ifdef SEL_SCAN_8_IDLE_EN
  localparam state_t     RST_STATE = S_IDLE;
  localparam logic [7:0] RST_SEL   = 8'h00;
`else
  localparam state_t     RST_STATE = S_RUN;
  localparam logic [7:0] RST_SEL   = 8'h01;
`endif

  state_t          state_q, state_d;
  logic [2:0]      idx_q, idx_d, idx_adv;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      sel_q, sel_d;
  logic            step_q, step_d;
  logic            wrap_q, wrap_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RST_STATE;
      idx_q   <= 3'd0;
      cnt_q   <= '0;
      sel_q   <= RST_SEL;
      step_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      step_q  <= step_d;
      wrap_q  <= wrap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    step_d  = 1'b0;
    wrap_d  = 1'b0;
    idx_adv = dir ? (idx_q - 3'd1) : (idx_q + 3'd1);
    case (state_q)
      S_RUN: begin
        // load outranks en/dir and restarts the prescaler
        if (load) begin
          idx_d = load_idx;
          cnt_d = '0;
        end else if (en) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d  = '0;
            idx_d  = idx_adv;
            step_d = 1'b1;
            wrap_d = dir ? (idx_q == 3'd0) : (idx_q == 3'd7);
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
`ifdef SEL_SCAN_8_IDLE_EN
        else begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
`endif
      end
`ifdef SEL_SCAN_8_IDLE_EN
      S_IDLE: begin
        if (load || en) begin
          state_d = S_RUN;
          cnt_d   = '0;
          if (load) idx_d = load_idx;
        end
      end
`endif
      default: state_d = RST_STATE;
    endcase
    // sel is registered alongside idx so the two never disagree
    sel_d = (state_d == S_RUN) ? (8'h01 << idx_d) : 8'h00;
  end

  assign sel  = sel_q;
  assign idx  = idx_q;
  assign step = step_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_sel_scan_8.sv
// Self-checking bench for sel_scan_8: three instances (PERIOD 4, 2, 1) share stimulus
// and are compared each cycle against a behavioural scan model.

module tb_sel_scan_8;

`ifdef SEL_SCAN_8_IDLE_EN
  localparam bit         IDLE_EN = 1'b1;
  localparam logic [7:0] RST_SEL = 8'h00;
  localparam int         LEAD    = 1;
`else
  localparam bit         IDLE_EN = 1'b0;
  localparam logic [7:0] RST_SEL = 8'h01;
  localparam int         LEAD    = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       dir = 1'b0;
  logic       load = 1'b0;
  logic [2:0] load_idx = 3'd0;

  logic [7:0] sel4, sel2, sel1;
  logic [2:0] idx4, idx2, idx1;
  logic       step4, step2, step1, wrap4, wrap2, wrap1;

  always #5 clk = ~clk;

  sel_scan_8 #(.PERIOD(4)) u_p4 (.clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .load(load),
    .load_idx(load_idx), .sel(sel4), .idx(idx4), .step(step4), .wrap(wrap4));
  sel_scan_8 #(.PERIOD(2)) u_p2 (.clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .load(load),
    .load_idx(load_idx), .sel(sel2), .idx(idx2), .step(step2), .wrap(wrap2));
  sel_scan_8 #(.PERIOD(1)) u_p1 (.clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .load(load),
    .load_idx(load_idx), .sel(sel1), .idx(idx1), .step(step1), .wrap(wrap1));

  // obs[k] = {sel, idx, step, wrap}; k=0 -> PERIOD 4, k=1 -> PERIOD 2, k=2 -> PERIOD 1
  logic [2:0][12:0] obs;
  assign obs = {{sel1, idx1, step1, wrap1}, {sel2, idx2, step2, wrap2}, {sel4, idx4, step4, wrap4}};

  int per [3] = '{4, 2, 1};
  int m_idx [3];
  int m_cnt [3];
  bit m_run [3];
  bit m_step [3];
  bit m_wrap [3];

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: count enabled cycles, step the index modulo 8 every PERIOD of them
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      m_step[k] = 1'b0;
      m_wrap[k] = 1'b0;
      if (!rst_n) begin
        m_idx[k] = 0;
        m_cnt[k] = 0;
        m_run[k] = !IDLE_EN;
      end else if (load) begin
        m_idx[k] = int'(load_idx);
        m_cnt[k] = 0;
        m_run[k] = 1'b1;
      end else if (!m_run[k]) begin
        if (en) begin
          m_run[k] = 1'b1;
          m_cnt[k] = 0;
        end
      end else if (!en) begin
        if (IDLE_EN) begin
          m_run[k] = 1'b0;
          m_cnt[k] = 0;
        end
      end else begin
        m_cnt[k] = m_cnt[k] + 1;
        if (m_cnt[k] == per[k]) begin
          m_cnt[k]  = 0;
          m_step[k] = 1'b1;
          m_wrap[k] = dir ? (m_idx[k] == 0) : (m_idx[k] == 7);
          m_idx[k]  = (m_idx[k] + (dir ? 7 : 1)) % 8;
        end
      end
    end
  end

  function automatic logic [12:0] expv(input int k);
    logic [7:0] s;
    s = m_run[k] ? (8'h01 << m_idx[k]) : 8'h00;
    return {s, 3'(m_idx[k]), m_step[k], m_wrap[k]};
  endfunction

  task automatic drive(input logic r, input logic e, input logic d, input logic l,
                       input logic [2:0] li);
    rst_n = r; en = e; dir = d; load = l; load_idx = li;
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b1, 1'b1, 1'b1, 3'd5);
    repeat (2) @(posedge clk);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (obs[k] !== expv(k)) begin
          n_bad++;
          $display("FAIL reset_model p=%0d t=%0t got=%h want=%h", per[k], $time, obs[k], expv(k));
        end
        n_cmp++;
        if (obs[k] !== {RST_SEL, 3'd0, 2'b00}) begin
          n_bad++;
          $display("FAIL reset_value p=%0d got=%h want=%h", per[k], obs[k], {RST_SEL, 3'd0, 2'b00});
        end
      end
    end
  endtask

  task automatic test_up_scan();
    int wraps;
    wraps = 0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (obs[k] !== expv(k)) begin
          n_bad++;
          $display("FAIL up_scan p=%0d t=%0t got=%h want=%h", per[k], $time, obs[k], expv(k));
        end
      end
      if (wrap4) begin
        wraps++;
        n_cmp++;
        if (sel4 !== 8'h01) begin
          n_bad++;
          $display("FAIL up_wrap_sel got=%h want=01", sel4);
        end
      end
    end
    n_cmp++;
    if (wraps != 1) begin
      n_bad++;
      $display("FAIL up_wrap_count got=%0d want=1", wraps);
    end
  endtask

  task automatic test_down_wrap();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 3'd0);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (obs[k] !== expv(k)) begin
          n_bad++;
          $display("FAIL down_scan p=%0d t=%0t got=%h want=%h", per[k], $time, obs[k], expv(k));
        end
      end
      if (c == LEAD + 2) begin
        n_cmp++;
        if (obs[1] !== {8'h80, 3'd7, 2'b11}) begin
          n_bad++;
          $display("FAIL down_wrap_p2 got=%h want=%h", obs[1], {8'h80, 3'd7, 2'b11});
        end
      end
    end
  endtask

  task automatic test_load();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
    repeat (LEAD + 2) @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 3'd5);
    @(negedge clk);
    n_cmp++;
    if (obs[0] !== {8'h20, 3'd5, 2'b00}) begin
      n_bad++;
      $display("FAIL load_p4 got=%h want=%h", obs[0], {8'h20, 3'd5, 2'b00});
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (obs[k] !== expv(k)) begin
          n_bad++;
          $display("FAIL load_run p=%0d t=%0t got=%h want=%h", per[k], $time, obs[k], expv(k));
        end
      end
      n_cmp++;
      if (c < 4 && step4 !== 1'b0) begin
        n_bad++;
        $display("FAIL load_early_step cyc=%0d got=%b want=0", c, step4);
      end else if (c == 4 && obs[0] !== {8'h40, 3'd6, 2'b10}) begin
        n_bad++;
        $display("FAIL load_next_step got=%h want=%h", obs[0], {8'h40, 3'd6, 2'b10});
      end
    end
  endtask

  task automatic test_en_toggle();
    logic [9:0] pat;
    pat = 10'b1110110011;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    @(negedge clk);
    for (int c = 0; c < 10; c++) begin
      drive(1'b1, pat[c], 1'b0, 1'b0, 3'd0);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (obs[k] !== expv(k)) begin
          n_bad++;
          $display("FAIL en_toggle p=%0d t=%0t got=%h want=%h", per[k], $time, obs[k], expv(k));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 3'd6);
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (idx4 !== 3'd6) begin
      n_bad++;
      $display("FAIL mid_pre_idx got=%0d want=6", idx4);
    end
    drive(1'b0, 1'b1, 1'b1, 1'b1, 3'd3);
    @(negedge clk);
    n_cmp++;
    if (obs[0] !== {RST_SEL, 3'd0, 2'b00}) begin
      n_bad++;
      $display("FAIL mid_reset got=%h want=%h", obs[0], {RST_SEL, 3'd0, 2'b00});
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
    for (int c = 1; c <= LEAD + 4; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (obs[k] !== expv(k)) begin
          n_bad++;
          $display("FAIL mid_resume p=%0d t=%0t got=%h want=%h", per[k], $time, obs[k], expv(k));
        end
      end
      n_cmp++;
      if (step4 !== (c == LEAD + 4)) begin
        n_bad++;
        $display("FAIL mid_step_delay cyc=%0d got=%b want=%b", c, step4, (c == LEAD + 4));
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      drive(($urandom_range(0, 49) != 0), ($urandom_range(0, 9) < 7), 1'($urandom),
            ($urandom_range(0, 11) == 0), 3'($urandom));
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (obs[k] !== expv(k)) begin
          n_bad++;
          $display("FAIL random p=%0d t=%0t got=%h want=%h", per[k], $time, obs[k], expv(k));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_up_scan();
    test_down_wrap();
    test_load();
    test_en_toggle();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
